// File: rtl/axi4_slave_wb_bridge.sv
// AXI4-Lite slave to pipelined Wishbone B4 master bridge.
// Each AXI read or write becomes exactly one WB cycle. Only one transaction is
// in flight at a time. Write and read requests that arrive together are
// arbitrated round-robin. A WB cycle that hangs is ended by an optional
// timeout that reports SLVERR.
module axi4_slave_wb_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    output logic [1:0]                s_axi_bresp,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    output logic [DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      wbm_cyc_o,
    output logic                      wbm_stb_o,
    output logic                      wbm_we_o,
    output logic [ADDR_WIDTH-1:0]     wbm_adr_o,
    output logic [DATA_WIDTH-1:0]     wbm_dat_o,
    output logic [DATA_WIDTH/8-1:0]   wbm_sel_o,
    input  logic                      wbm_stall_i,
    input  logic                      wbm_ack_i,
    input  logic                      wbm_err_i,
    input  logic [DATA_WIDTH-1:0]     wbm_dat_i
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    // A zero-width counter is illegal, so TIMEOUT=0 still gets one (unused) bit.
    localparam int CNT_WIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WB_REQ,
        WB_WAIT,
        B_RESP,
        R_RESP
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    last_write;
    logic                    we;
    logic [ADDR_WIDTH-1:0]   adr;
    logic [DATA_WIDTH-1:0]   dat;
    logic [STRB_WIDTH-1:0]   sel;
    logic [1:0]              resp;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [CNT_WIDTH-1:0]    cnt;

    logic                    wr_elig;
    logic                    rd_elig;
    logic                    grant_wr;
    logic                    grant_rd;
    logic                    in_cycle;
    logic                    resp_phase;
    logic                    term_ack;
    logic                    term_err;
    logic                    term_to;
    logic                    term;

    // Arbitration: a write needs both AW and W; on a tie the type not served last wins.
    always_comb begin
        wr_elig  = s_axi_awvalid & s_axi_wvalid;
        rd_elig  = s_axi_arvalid;
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if ((state == IDLE) && !wb_rst_i) begin
            if (wr_elig && (!rd_elig || !last_write)) begin
                grant_wr = 1'b1;
            end else if (rd_elig) begin
                grant_rd = 1'b1;
            end
        end
    end

    // WB termination: ack/err count once stb has been accepted; err beats ack, and either beats timeout.
    always_comb begin
        in_cycle   = (state == WB_REQ) || (state == WB_WAIT);
        resp_phase = (state == WB_WAIT) || ((state == WB_REQ) && !wbm_stall_i);
        term_err   = resp_phase & wbm_err_i;
        term_ack   = resp_phase & wbm_ack_i & ~wbm_err_i;
        term_to    = in_cycle & ~(term_ack | term_err) & (TIMEOUT != 0) & (cnt == CNT_LAST);
        term       = term_ack | term_err | term_to;
    end

    // State register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_wr || grant_rd) begin
                    state_next = WB_REQ;
                end
            end
            WB_REQ: begin
                if (term) begin
                    state_next = we ? B_RESP : R_RESP;
                end else if (!wbm_stall_i) begin
                    state_next = WB_WAIT;
                end
            end
            WB_WAIT: begin
                if (term) begin
                    state_next = we ? B_RESP : R_RESP;
                end
            end
            B_RESP: begin
                if (s_axi_bready) begin
                    state_next = IDLE;
                end
            end
            R_RESP: begin
                if (s_axi_rready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request capture, timeout counter and response capture.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            last_write <= 1'b0;
            we         <= 1'b0;
            adr        <= '0;
            dat        <= '0;
            sel        <= '0;
            resp       <= RESP_OKAY;
            rdata      <= '0;
            cnt        <= '0;
        end else begin
            if (grant_wr) begin
                adr        <= s_axi_awaddr;
                dat        <= s_axi_wdata;
                sel        <= s_axi_wstrb;
                we         <= 1'b1;
                cnt        <= '0;
                last_write <= 1'b1;
            end else if (grant_rd) begin
                adr        <= s_axi_araddr;
                sel        <= '1;
                we         <= 1'b0;
                cnt        <= '0;
                last_write <= 1'b0;
            end else if (in_cycle && (cnt != CNT_MAX)) begin
                cnt <= cnt + 1'b1;
            end
            if (term) begin
                resp <= term_ack ? RESP_OKAY : RESP_SLVERR;
                if (!we) begin
                    rdata <= term_ack ? wbm_dat_i : '0;
                end
            end
        end
    end

    // Handshake and bus outputs decode straight from state so reset clears them at once.
    assign s_axi_awready = grant_wr;
    assign s_axi_wready  = grant_wr;
    assign s_axi_arready = grant_rd;
    assign s_axi_bvalid  = (state == B_RESP);
    assign s_axi_rvalid  = (state == R_RESP);
    assign s_axi_bresp   = resp;
    assign s_axi_rresp   = resp;
    assign s_axi_rdata   = rdata;
    assign wbm_cyc_o     = in_cycle;
    assign wbm_stb_o     = (state == WB_REQ);
    assign wbm_we_o      = we & in_cycle;
    assign wbm_adr_o     = adr;
    assign wbm_dat_o     = dat;
    assign wbm_sel_o     = sel;

endmodule
